// File: rtl/dav_eoc_bridge_pkg.sv
// Shared definitions for the dav_/rfd -> soc/eoc bridge.
//   rx_state_t : producer-side handshake states (dav_/rfd)
//   tx_state_t : initiator-side handshake states (soc/eoc)
//   clog2()    : ceiling log2 for sizing pointers, level and counters
package dav_eoc_bridge_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_WAIT = 2'd1,
    T_CONV = 2'd2
  } tx_state_t;

  // clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dav_eoc_bridge_fifo.sv
// hs_sync_fifo: single-clock FIFO with DEPTH (power of two) entries.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   push, wdata  : write request and word; ignored when full unless a pop
//                  happens in the same clock
//   pop          : read request; ignored when empty
//   rdata        : current head word (combinational read)
//   full, empty  : occupancy flags derived from level
//   level        : number of stored words, 0..DEPTH
module hs_sync_fifo
  import dav_eoc_bridge_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same clock, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only and is left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dav_eoc_bridge.sv
// dav_eoc_bridge: accepts words over a dav_/rfd handshake, buffers them in a
// DEPTH-entry FIFO and serves them over a soc/eoc "conversion" handshake.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   dav_, in_data: producer data-valid (active low) and word
//   rfd          : acknowledge to producer, high while a word is taken
//   soc          : start-of-conversion from the initiator
//   eoc          : 1 = idle / result valid, 0 = conversion in progress
//   out_data     : result word, changes only as eoc falls
//   level        : FIFO occupancy
module dav_eoc_bridge
  import dav_eoc_bridge_pkg::*;
#(
  parameter int N           = 8,
  parameter int M           = 8,
  parameter int DEPTH       = 4,
  parameter int CONV_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dav_,
  output logic                  rfd,
  input  logic [N-1:0]          in_data,
  input  logic                  soc,
  output logic                  eoc,
  output logic [M-1:0]          out_data,
  output logic [clog2(DEPTH):0] level
);

  localparam int CW = clog2(CONV_CYCLES + 1);

  rx_state_t     rx_state;
  tx_state_t     tx_state;
  logic [CW-1:0] conv_cnt;
  logic [N-1:0]  fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Truncate to the M LSBs or zero-extend, depending on M versus N.
  function automatic logic [M-1:0] fit_width(input logic [N-1:0] w);
    return M'(w);
  endfunction

  // Pop uses the registered empty flag, so a word pushed this clock cannot
  // be popped until the next one.
  assign pop  = (tx_state == T_IDLE) && soc && !fifo_empty;
  assign push = (rx_state == R_IDLE) && !dav_ && (!fifo_full || pop);

  hs_sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Producer side: one push per dav_ low pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= R_IDLE;
      rfd      <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (push) begin
            rfd      <= 1'b1;
            rx_state <= R_ACK;
          end
        end
        R_ACK: begin
          if (dav_) begin
            rfd      <= 1'b0;
            rx_state <= R_IDLE;
          end
        end
        default: begin
          rfd      <= 1'b0;
          rx_state <= R_IDLE;
        end
      endcase
    end
  end

  // Initiator side: eoc rises exactly CONV_CYCLES clocks after soc=0 is
  // first sampled in T_WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= T_IDLE;
      eoc      <= 1'b1;
      out_data <= '0;
      conv_cnt <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (pop) begin
            eoc      <= 1'b0;
            out_data <= fit_width(fifo_rdata);
            tx_state <= T_WAIT;
          end
        end
        T_WAIT: begin
          if (!soc) begin
            conv_cnt <= CW'(CONV_CYCLES - 1);
            tx_state <= T_CONV;
          end
        end
        T_CONV: begin
          if (conv_cnt == '0) begin
            eoc      <= 1'b1;
            tx_state <= T_IDLE;
          end else begin
            conv_cnt <= conv_cnt - 1'b1;
          end
        end
        default: begin
          eoc      <= 1'b1;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

endmodule
